sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one dual-port 16K x 128 SRAM macro among NREQ requesters. Port A is write-only and port B is read-only.
- Contains two independent round-robin arbiters: a write arbiter driving port A and a read arbiter driving port B. One write and one read can be granted in the same cycle.
- Registers the SRAM control signals and returns read data to the owning requester after a fixed latency.
- Sits between the DMA/NPU-core request fabric and the SRAM instance.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 14, SRAM word address width.
- DW, 128, SRAM data width.

Ports:
- clk  in  1  single clock for the arbiter and both SRAM ports.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_we  in  NREQ  1 = write request, 0 = read request.
- req_addr  in  NREQ*AW  flattened word addresses; requester i uses bits [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- req_ready  out  NREQ  grant for the current cycle (combinational).
- rsp_valid  out  NREQ  one-hot read-response strobe.
- rsp_rdata  out  DW  read data; valid only while any rsp_valid bit is set.
- sram_ena  out  1  port A enable.
- sram_wea  out  1  port A write enable.
- sram_addra  out  AW  port A address.
- sram_dina  out  DW  port A write data.
- sram_enb  out  1  port B enable.
- sram_addrb  out  AW  port B address.
- sram_doutb  in  DW  port B data; registered in the SRAM, valid one cycle after the enb edge.

Behaviour:
- Handshake
  - A request is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
  - req_ready[i] depends combinationally on req_valid, req_we, req_addr and the arbiter pointers.
  - A requester must hold valid, we, addr and wdata stable until accepted.
  - Responses cannot be backpressured.
- Write arbiter
  - Candidates: requesters with valid=1 and we=1.
  - Grants the first candidate at or after wr_ptr, searching upward modulo NREQ.
  - After a grant, wr_ptr = granted index + 1 (mod NREQ). No grant leaves wr_ptr unchanged.
- Read arbiter
  - Same algorithm over candidates with valid=1 and we=0, using rd_ptr.
- Collision rule
  - The SRAM returns old data when a read and a write to the same address share an edge.
  - Therefore, if the winning write and the winning read have equal addresses in a cycle, the read is not granted: its req_ready is 0 and rd_ptr is unchanged.
  - That read is re-arbitrated in the next cycle.
- Issue stage (registered)
  - On write acceptance in cycle T, during T+1: sram_ena=1, sram_wea=1, and sram_addra/sram_dina hold the accepted values. Data is committed at the end of T+1.
  - On read acceptance in cycle T, during T+1: sram_enb=1, sram_addrb = accepted address, and the owner id is registered.
  - With no acceptance, ena, wea and enb are 0 in T+1. addra, dina and addrb hold their previous values.
- Response stage
  - Owner id is pipelined one more stage.
  - In cycle T+2, rsp_valid[owner]=1 and rsp_rdata = sram_doutb (pass-through).
  - Read latency is exactly 2 cycles from acceptance.
  - Throughput is 1 read/cycle plus 1 write/cycle sustained.
- Ordering
  - A read accepted at T or later observes every write accepted at T-1 or earlier.
  - A same-cycle same-address pair is serialized write-first by the collision rule.
- Reset (rstn low, asynchronous)
  - wr_ptr and rd_ptr go to 0.
  - sram_ena, sram_wea, sram_enb go to 0; sram_addra, sram_addrb, sram_dina go to 0.
  - rsp_valid goes to 0; rsp_rdata = sram_doutb (unregistered).
  - req_ready is 0 while rstn is low.
  - In-flight reads are dropped with no response. Writes already presented on port A are not cancelled if the clock edge has already occurred.
- Boundaries
  - Address 0x3FFF is legal; there is no wrap or checking.
  - NREQ=1 degenerates to an always-granting pass-through.
  - All requesters idle: no strobes.

Test Plan:
1. Single write then read: requester 0 writes addr 0x0010, data 0xA5..A5 (128b); at cycle +3, requester 1 reads 0x0010 -> rsp_valid=3'b010 exactly 2 cycles after acceptance, rsp_rdata=0xA5..A5.
2. Concurrent ports: req0 writes 0x0001 while req1 reads 0x0002, preloaded with 0x1234 -> both req_ready=1 in the same cycle; rsp_valid=3'b010 at +2 with data 0x1234.
3. Collision: req0 writes 0x0100=0xBEEF while req2 reads 0x0100 in the same cycle (old value 0) -> req_ready[2]=0 that cycle and 1 the next; response data 0xBEEF.
4. Round-robin fairness: all three requesters read continuously for 9 cycles from reset -> grants in order 0,1,2,0,1,2,0,1,2; 9 responses, each exactly 2 cycles after its grant.
5. Reset mid-operation: rstn driven low 1 cycle after a read acceptance -> no rsp_valid pulse; all outputs 0; after release, the first grant goes to requester 0.
6. Top address: write then read 0x3FFF with an all-ones pattern -> all-ones returned; address 0x0000 unaffected.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Request/response and SRAM-port bundle shared by the arbiter and its environment.
// The slave modport is the arbiter's view; master is the fabric/SRAM side.
interface sram_port_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 14,
  parameter int DW   = 128
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               sram_ena;
  logic               sram_wea;
  logic [AW-1:0]      sram_addra;
  logic [DW-1:0]      sram_dina;
  logic               sram_enb;
  logic [AW-1:0]      sram_addrb;
  logic [DW-1:0]      sram_doutb;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_doutb,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_ena, sram_wea, sram_addra, sram_dina, sram_enb, sram_addrb
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_doutb,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_ena, sram_wea, sram_addra, sram_dina, sram_enb, sram_addrb
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two independent round-robin arbiters sharing a write-only port A and a read-only
// port B of one SRAM; read data returns to its owner exactly two cycles after grant.
module sram_port_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 14,
  parameter int DW   = 128
) (
  input  logic                  clk,
  input  logic                  rstn,
  sram_port_arbiter_if.slave    bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = PW + 1;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [NREQ-1:0] wr_cand;
  logic [NREQ-1:0] rd_cand;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = bus.req_wdata[gi*DW +: DW];
      assign wr_cand[gi]   = bus.req_valid[gi] & bus.req_we[gi];
      assign rd_cand[gi]   = bus.req_valid[gi] & ~bus.req_we[gi];
    end
  endgenerate

  // Returns {found, index} of the first candidate at or after ptr, modulo NREQ.
  // Scanning from the far end down lets the nearest candidate overwrite the result.
  function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] cand,
                                            input logic [PW-1:0]   ptr);
    logic [SW-1:0] res;
    logic [SW-1:0] pos;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(NREQ)) begin
        pos = pos - SW'(NREQ);
      end
      if (cand[pos[PW-1:0]]) begin
        res = {1'b1, pos[PW-1:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    return (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_next, rd_ptr_next;
  logic [SW-1:0]   wr_sel, rd_sel;
  logic            wr_found, rd_found, rd_blocked, rd_go;
  logic [PW-1:0]   wr_idx, rd_idx;
  logic [NREQ-1:0] wr_oh, rd_oh;

  assign wr_sel   = rr_pick(wr_cand, wr_ptr_reg);
  assign rd_sel   = rr_pick(rd_cand, rd_ptr_reg);
  assign wr_found = wr_sel[PW];
  assign rd_found = rd_sel[PW];
  assign wr_idx   = wr_sel[PW-1:0];
  assign rd_idx   = rd_sel[PW-1:0];

  // A same-address read would see pre-write data, so it waits one cycle behind the write.
  assign rd_blocked = wr_found & rd_found & (addr_arr[wr_idx] == addr_arr[rd_idx]);
  assign rd_go      = rd_found & ~rd_blocked;

  assign wr_ptr_next = wr_found ? ptr_after(wr_idx) : wr_ptr_reg;
  assign rd_ptr_next = rd_go    ? ptr_after(rd_idx) : rd_ptr_reg;

  assign wr_oh = wr_found ? (NREQ'(1) << wr_idx) : '0;
  assign rd_oh = rd_go    ? (NREQ'(1) << rd_idx) : '0;

  assign bus.req_ready = rstn ? (wr_oh | rd_oh) : '0;

  logic          ena_reg, wea_reg, enb_reg;
  logic [AW-1:0] addra_reg, addrb_reg;
  logic [DW-1:0] dina_reg;
  logic [PW-1:0] owner1_reg, owner2_reg;
  logic          rsp_vld_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      ena_reg     <= 1'b0;
      wea_reg     <= 1'b0;
      enb_reg     <= 1'b0;
      addra_reg   <= '0;
      addrb_reg   <= '0;
      dina_reg    <= '0;
      owner1_reg  <= '0;
      owner2_reg  <= '0;
      rsp_vld_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      ena_reg    <= wr_found;
      wea_reg    <= wr_found;
      enb_reg    <= rd_go;
      if (wr_found) begin
        addra_reg <= addr_arr[wr_idx];
        dina_reg  <= wdata_arr[wr_idx];
      end
      if (rd_go) begin
        addrb_reg  <= addr_arr[rd_idx];
        owner1_reg <= rd_idx;
      end
      rsp_vld_reg <= enb_reg;
      owner2_reg  <= owner1_reg;
    end
  end

  assign bus.sram_ena   = ena_reg;
  assign bus.sram_wea   = wea_reg;
  assign bus.sram_addra = addra_reg;
  assign bus.sram_dina  = dina_reg;
  assign bus.sram_enb   = enb_reg;
  assign bus.sram_addrb = addrb_reg;

  assign bus.rsp_valid = rsp_vld_reg ? (NREQ'(1) << owner2_reg) : '0;
  assign bus.rsp_rdata = bus.sram_doutb;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench: a behavioural arbitration/memory model predicts grants
// and read data; a separate monitor matches every response strobe against a queue.
module tb_sram_port_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 14;
  localparam int DW   = 128;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  sram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro model: read-before-write on a shared edge, registered output.
  bit [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.sram_enb) bus.sram_doutb <= mem[bus.sram_addrb];
    if (bus.sram_ena && bus.sram_wea) mem[bus.sram_addra] <= bus.sram_dina;
  end

  // Requester state and reference model
  bit            pv    [NREQ];
  bit            pwe   [NREQ];
  logic [AW-1:0] paddr [NREQ];
  logic [DW-1:0] pdata [NREQ];
  int            wptr = 0;
  int            rptr = 0;
  bit [DW-1:0]   ref_mem [0:(1<<AW)-1];

  typedef struct {
    int          owner;
    logic [DW-1:0] data;
    int          due;
  } rsp_t;
  rsp_t sbq[$];

  logic [NREQ-1:0] last_ready;
  logic [DW-1:0]   last_rsp_data;
  int              last_rsp_owner = -1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input bit [NREQ-1:0] cand, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[i]    = 1'b1;
    pwe[i]   = we;
    paddr[i] = a;
    pdata[i] = d;
  endtask

  // One clock: drive, evaluate the model at the negedge, compare grants, advance.
  task automatic step();
    bit [NREQ-1:0] wc, rc, exp_rdy;
    int w, r;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]           = pv[i];
      bus.req_we[i]              = pwe[i];
      bus.req_addr[i*AW +: AW]   = paddr[i];
      bus.req_wdata[i*DW +: DW]  = pdata[i];
    end
    @(negedge clk);
    exp_rdy = '0;
    if (rstn) begin
      for (int i = 0; i < NREQ; i++) begin
        wc[i] = pv[i] && pwe[i];
        rc[i] = pv[i] && !pwe[i];
      end
      w = pick(wc, wptr);
      r = pick(rc, rptr);
      if (w >= 0 && r >= 0 && paddr[w] == paddr[r]) r = -1;
      if (r >= 0) begin
        exp_rdy[r] = 1'b1;
        sbq.push_back('{r, ref_mem[paddr[r]], cyc + 2});
        rptr  = (r + 1) % NREQ;
        pv[r] = 1'b0;
      end
      if (w >= 0) begin
        exp_rdy[w] = 1'b1;
        ref_mem[paddr[w]] = pdata[w];
        wptr  = (w + 1) % NREQ;
        pv[w] = 1'b0;
      end
    end
    last_ready = bus.req_ready;
    chk("req_ready", DW'(bus.req_ready), DW'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((pv[0] || pv[1] || pv[2] || sbq.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    n_vec++;
    if (n >= maxc) begin
      n_err++;
      $display("FAIL run_idle: %0d responses outstanding after %0d cycles, required 0", sbq.size(), maxc);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sram_ena",   DW'(bus.sram_ena),   '0);
    chk("rst_sram_wea",   DW'(bus.sram_wea),   '0);
    chk("rst_sram_enb",   DW'(bus.sram_enb),   '0);
    chk("rst_sram_addra", DW'(bus.sram_addra), '0);
    chk("rst_sram_addrb", DW'(bus.sram_addrb), '0);
    chk("rst_sram_dina",  bus.sram_dina,       '0);
    chk("rst_rsp_valid",  DW'(bus.rsp_valid),  '0);
    chk("rst_req_ready",  DW'(bus.req_ready),  '0);
  endtask

  task automatic enter_reset();
    rstn = 1'b0;
    sbq.delete();
    wptr = 0;
    rptr = 0;
  endtask

  // Response monitor: pops one expectation per strobe, flags strays and misses.
  rsp_t e;
  always @(negedge clk) begin
    if (bus.rsp_valid != '0) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", DW'(bus.rsp_valid), '0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_valid",   DW'(bus.rsp_valid), DW'(NREQ'(1) << e.owner));
        chk("rsp_latency", DW'(cyc),           DW'(e.due));
        chk("rsp_rdata",   bus.rsp_rdata,      e.data);
        last_rsp_data  = bus.rsp_rdata;
        last_rsp_owner = e.owner;
        $display("rsp req%0d data %h cycle %0d", e.owner, bus.rsp_rdata, cyc);
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("rsp_missing", DW'(bus.rsp_valid), DW'(NREQ'(1) << e.owner));
    end
  end

  initial begin
    logic [DW-1:0] ones;
    ones = '1;
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
    end

    // Reset: a pending read must not be granted while rstn is low
    set_req(1, 1'b0, AW'(5), '0);
    step();
    chk_reset_outputs();
    step();
    rstn = 1'b1;
    run_idle(50);

    // 1. Single write then read
    set_req(0, 1'b1, AW'('h10), {16{8'hA5}});
    run_idle(50);
    step(); step(); step();
    set_req(1, 1'b0, AW'('h10), '0);
    run_idle(50);
    chk("t1_rdata", last_rsp_data, {16{8'hA5}});
    chk("t1_owner", DW'(last_rsp_owner), DW'(1));

    // 2. Concurrent ports
    set_req(1, 1'b1, AW'('h2), DW'('h1234));
    run_idle(50);
    set_req(0, 1'b1, AW'('h1), {$urandom, $urandom, $urandom, $urandom});
    set_req(1, 1'b0, AW'('h2), '0);
    step();
    chk("t2_ready", DW'(last_ready), DW'(3'b011));
    run_idle(50);
    chk("t2_rdata", last_rsp_data, DW'('h1234));

    // 3. Same-cycle same-address collision
    set_req(0, 1'b1, AW'('h100), DW'('hBEEF));
    set_req(2, 1'b0, AW'('h100), '0);
    step();
    chk("t3_ready_first", DW'(last_ready), DW'(3'b001));
    step();
    chk("t3_ready_second", DW'(last_ready), DW'(3'b100));
    run_idle(50);
    chk("t3_rdata", last_rsp_data, DW'('hBEEF));

    // 4. Round-robin fairness from reset
    enter_reset();
    step();
    chk_reset_outputs();
    rstn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pv[i]) set_req(i, 1'b0, AW'($urandom_range(0, 15)), '0);
      step();
      chk("t4_grant", DW'(last_ready), DW'(NREQ'(1) << (k % 3)));
    end
    run_idle(50);

    // 5. Reset one cycle after a read acceptance
    set_req(1, 1'b0, AW'('h10), '0);
    step();
    enter_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0);
    step();
    chk_reset_outputs();
    step();
    rstn = 1'b1;
    step();
    chk("t5_first_grant", DW'(last_ready), DW'(3'b001));
    run_idle(50);

    // 6. Top address
    set_req(2, 1'b1, AW'('h3FFF), ones);
    run_idle(50);
    set_req(0, 1'b0, AW'('h3FFF), '0);
    run_idle(50);
    chk("t6_top_rdata", last_rsp_data, ones);
    set_req(1, 1'b0, AW'(0), '0);
    run_idle(50);
    chk("t6_addr0", last_rsp_data, '0);

    // Randomized traffic over a small address set to provoke collisions
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          int sel;
          sel = $urandom_range(0, 8);
          set_req(i, 1'($urandom_range(0, 1)), (sel == 8) ? AW'('h3FFF) : AW'(sel),
                  {$urandom, $urandom, $urandom, $urandom});
        end
      end
      step();
    end
    run_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
